robo_limpa_tubos: RTL and testbench

- Controller for a pipe-cleaning robot that follows walls with the wall kept on its left.
- It moves through a grid map one cell per action.
- Each clock cycle it samples four sensors and issues at most one action: step forward, turn left 90°, or remove trash.
- Trash blocking the path is cleared by three consecutive remove cycles. A floor marker stops the robot after it has moved.

---
 rtl/robo_limpa_tubos.sv | 136 +++++++++++++
 tb/tb_robo_limpa_tubos.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/robo_limpa_tubos.sv
// Left-wall-following controller for a pipe-cleaning robot: one action per cycle (front / turn / remove).
// Latency: one cycle; sensors sampled at a rising edge drive the registered action visible until the next edge.
// Backpressure: none; the robot issues an action every cycle except in DONE, where it stays idle until reset.
module robo_limpa_tubos #(
  parameter int REMOVE_CYCLES = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic head,
  input  logic left,
  input  logic under,
  input  logic barrier,
  output logic front,
  output logic turn,
  output logic remove
);

  typedef enum logic [1:0] {
    ST_FOLLOW,
    ST_REMOVE,
    ST_ROT,
    ST_DONE
  } state_t;

  // A right turn is done as three consecutive left turns.
  localparam logic [1:0] REM_LAST = 2'(REMOVE_CYCLES);
  localparam logic [1:0] ROT_LAST = 2'd3;

  state_t     state;
  logic [1:0] rem_cnt;
  logic [1:0] rot_cnt;
  logic       just_turned;
  logic       moved;

  // Outcome of one wall-following decision on the current sensor sample.
  state_t     f_state;
  logic       f_front;
  logic       f_turn;
  logic       f_remove;
  logic       f_just_turned;
  logic       f_moved;
  logic [1:0] f_rem_cnt;
  logic [1:0] f_rot_cnt;
  logic       follow_eval;

  // A finished removal or rotation hands over to the follow rules on the
  // same edge, so the robot never idles between sequences.
  assign follow_eval = (state == ST_FOLLOW) ||
                       ((state == ST_REMOVE) && (rem_cnt >= REM_LAST)) ||
                       ((state == ST_ROT) && (rot_cnt >= ROT_LAST));

  // Wall-following rules in priority order: trash, stop marker, gap on the
  // left, straight ahead, blocked ahead.
  always_comb begin
    f_state       = ST_FOLLOW;
    f_front       = 1'b0;
    f_turn        = 1'b0;
    f_remove      = 1'b0;
    f_just_turned = just_turned;
    f_moved       = moved;
    f_rem_cnt     = 2'd0;
    f_rot_cnt     = 2'd0;
    if (barrier) begin
      f_remove      = 1'b1;
      f_state       = ST_REMOVE;
      f_rem_cnt     = 2'd1;
      f_just_turned = 1'b0;
    end else if (under && moved) begin
      // The marker only counts once the robot has left its start cell.
      f_state = ST_DONE;
    end else if (!left && !just_turned) begin
      // Opening on the left: turn into it, then step through next cycle.
      f_turn        = 1'b1;
      f_just_turned = 1'b1;
    end else if (!head) begin
      // Either wall on the left, or already turned toward the opening.
      f_front       = 1'b1;
      f_just_turned = 1'b0;
      f_moved       = 1'b1;
    end else begin
      // Blocked ahead: first of three left turns making a right turn.
      f_turn        = 1'b1;
      f_state       = ST_ROT;
      f_rot_cnt     = 2'd1;
      f_just_turned = 1'b0;
    end
  end

  // Controller state, counters, flags and registered actions.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_FOLLOW;
      rem_cnt     <= 2'd0;
      rot_cnt     <= 2'd0;
      just_turned <= 1'b0;
      moved       <= 1'b0;
      front       <= 1'b0;
      turn        <= 1'b0;
      remove      <= 1'b0;
    end else if (follow_eval) begin
      state       <= f_state;
      rem_cnt     <= f_rem_cnt;
      rot_cnt     <= f_rot_cnt;
      just_turned <= f_just_turned;
      moved       <= f_moved;
      front       <= f_front;
      turn        <= f_turn;
      remove      <= f_remove;
    end else begin
      case (state)
        ST_REMOVE: begin
          // Sensors ignored while the trash is being cleared.
          rem_cnt <= rem_cnt + 2'd1;
          front   <= 1'b0;
          turn    <= 1'b0;
          remove  <= 1'b1;
        end
        ST_ROT: begin
          // Sensors ignored until the right turn is complete.
          rot_cnt <= rot_cnt + 2'd1;
          front   <= 1'b0;
          turn    <= 1'b1;
          remove  <= 1'b0;
        end
        default: begin
          // DONE: parked on the marker until reset.
          state  <= ST_DONE;
          front  <= 1'b0;
          turn   <= 1'b0;
          remove <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_robo_limpa_tubos.sv
// Directed bench for robo_limpa_tubos: vector table plus async-reset abort sequences.
// Each vector drives sensors at the falling edge and checks the action just after the next rising edge.
// Expected actions are hand-derived from the wall-following rules.
module tb_robo_limpa_tubos;

  logic clock   = 1'b0;
  logic reset   = 1'b0;
  logic head    = 1'b0;
  logic left    = 1'b0;
  logic under   = 1'b0;
  logic barrier = 1'b0;
  logic front;
  logic turn;
  logic remove;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {front, turn, remove}
  localparam logic [2:0] Z = 3'b000;
  localparam logic [2:0] F = 3'b100;
  localparam logic [2:0] T = 3'b010;
  localparam logic [2:0] R = 3'b001;

  robo_limpa_tubos #(.REMOVE_CYCLES(3)) dut (
    .clock  (clock),
    .reset  (reset),
    .head   (head),
    .left   (left),
    .under  (under),
    .barrier(barrier),
    .front  (front),
    .turn   (turn),
    .remove (remove)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       h;
    logic       l;
    logic       u;
    logic       b;
    logic [2:0] exp;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic rst, input logic h, input logic l,
                              input logic u, input logic b, input logic [2:0] exp);
    vec_t v;
    v.rst = rst;
    v.h   = h;
    v.l   = l;
    v.u   = u;
    v.b   = b;
    v.exp = exp;
    vt.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [2:0] exp);
    n_checks++;
    if ({front, turn, remove} !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: front/turn/remove = %b, expected %b",
               name, idx, {front, turn, remove}, exp);
    end
  endtask

  task automatic step(input logic rst, input logic h, input logic l,
                      input logic u, input logic b);
    @(negedge clock);
    reset   = rst;
    head    = h;
    left    = l;
    under   = u;
    barrier = b;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //   rst h  l  u  b  expected
    // reset held with head and barrier asserted, then plain wall following
    add(0, 1, 0, 0, 1, Z);
    add(1, 0, 1, 0, 0, F);
    add(1, 0, 1, 0, 0, F);
    add(1, 0, 1, 0, 0, F);
    // corner: three turns with sensors ignored, then forward
    add(1, 1, 1, 0, 0, T);
    add(1, 0, 0, 1, 1, T);
    add(1, 0, 0, 0, 1, T);
    add(1, 0, 1, 0, 0, F);
    // gap on left: turn, step through, turn again
    add(1, 0, 0, 0, 0, T);
    add(1, 0, 0, 0, 0, F);
    add(1, 0, 0, 0, 0, T);
    // trash: exactly three removes, sensors ignored meanwhile
    add(1, 0, 1, 0, 1, R);
    add(1, 1, 0, 0, 0, R);
    add(1, 0, 1, 0, 1, R);
    add(1, 0, 1, 0, 0, F);
    // back-to-back trash: barrier at the exit edge starts a fresh removal
    add(1, 0, 1, 0, 1, R);
    add(1, 0, 1, 0, 1, R);
    add(1, 0, 1, 0, 1, R);
    add(1, 0, 1, 0, 1, R);
    add(1, 0, 1, 0, 0, R);
    add(1, 0, 1, 0, 0, R);
    add(1, 0, 1, 0, 0, F);
    // turned into gap but blocked ahead: right turn sequence
    add(1, 0, 0, 0, 0, T);
    add(1, 1, 0, 0, 0, T);
    add(1, 1, 0, 0, 0, T);
    add(1, 1, 0, 0, 0, T);
    add(1, 0, 1, 0, 0, F);
    // stop marker after moving: idle forever
    add(1, 0, 1, 1, 0, Z);
    add(1, 0, 1, 0, 0, Z);
    add(1, 1, 0, 0, 1, Z);
    // marker at start ignored until the first step
    add(0, 0, 1, 0, 0, Z);
    add(1, 0, 1, 1, 0, F);
    add(1, 0, 1, 1, 0, Z);
    add(0, 0, 0, 0, 0, Z);
    add(1, 0, 0, 1, 0, T);
    add(1, 0, 0, 1, 0, F);
    add(1, 0, 0, 1, 0, Z);
    // barrier beats marker
    add(0, 0, 0, 0, 0, Z);
    add(1, 0, 1, 0, 0, F);
    add(1, 0, 1, 1, 1, R);
    add(1, 0, 1, 1, 0, R);
    add(1, 0, 1, 1, 0, R);
    add(1, 0, 1, 1, 0, Z);

    foreach (vt[i]) begin
      step(vt[i].rst, vt[i].h, vt[i].l, vt[i].u, vt[i].b);
      check("vec", i, vt[i].exp);
    end

    // Async reset during removal cycle 2
    step(0, 0, 0, 0, 0);
    check("rem_rst_hold", 0, Z);
    step(1, 0, 1, 0, 1);
    check("rem_cycle", 1, R);
    step(1, 0, 1, 0, 1);
    check("rem_cycle", 2, R);
    #2;
    reset = 1'b0;
    #1;
    check("rem_async_abort", 0, Z);
    step(0, 0, 1, 0, 1);
    check("rem_rst_hold", 1, Z);
    step(1, 0, 1, 0, 1);
    check("rem_fresh", 1, R);
    step(1, 0, 1, 0, 1);
    check("rem_fresh", 2, R);
    step(1, 0, 1, 0, 1);
    check("rem_fresh", 3, R);
    step(1, 0, 1, 0, 0);
    check("rem_after", 0, F);

    // Async reset during rotation
    step(1, 1, 1, 0, 0);
    check("rot_cycle", 1, T);
    step(1, 1, 1, 0, 0);
    check("rot_cycle", 2, T);
    #2;
    reset = 1'b0;
    #1;
    check("rot_async_abort", 0, Z);
    step(1, 0, 1, 0, 0);
    check("rot_after", 0, F);
    step(1, 0, 1, 0, 0);
    check("rot_after", 1, F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
